wb_bus_arbiter: RTL and testbench

//  Two-master arbiter for the shared pipelined Wishbone peripheral bus (SRAM, SSEG, switch/LED, keys).
//  M0 = core data port, M1 = secondary master (debug loader / DMA). Sits between the masters and the

---
 rtl/wb_arb_pkg.sv | 20 ++
 rtl/wb_arb_tracker.sv | 64 ++++++
 rtl/wb_bus_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_wb_bus_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and default widths for the two-master Wishbone arbiter.
//   arb_state_t  : arbiter FSM states (idle / bus owned / aborted on slave timeout)
//   master_idx_t : index of a master (0 = core data port, 1 = secondary master)
//   onehot()     : converts a master index to the one-hot grant vector
package wb_arb_pkg;

  typedef enum logic [1:0] {StIdle, StOwn, StAbort} arb_state_t;

  typedef logic [0:0] master_idx_t;

  localparam int unsigned DefAw       = 30;
  localparam int unsigned DefDw       = 32;
  localparam int unsigned DefMaxOutst = 4;
  localparam int unsigned DefTimeout  = 1024;

  function automatic logic [1:0] onehot(master_idx_t idx);
    return idx[0] ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/wb_arb_tracker.sv
// Outstanding-request counter and slave-timeout timer for the bus owner.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   accept_i      : a request was accepted by the fabric this cycle
//   resp_i        : an ack/err for an outstanding request arrived this cycle
//   clear_i       : drop all tracking (owner leaving the bus, abort, idle)
//   cap_o         : outstanding count is at MaxOutst; owner must be stalled
//   empty_o       : nothing outstanding; responses must be dropped
//   timeout_o     : outstanding requests went Timeout cycles without a response
module wb_arb_tracker #(
  parameter int unsigned MaxOutst = 4,
  parameter int unsigned Timeout  = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic accept_i,
  input  logic resp_i,
  input  logic clear_i,
  output logic cap_o,
  output logic empty_o,
  output logic timeout_o
);

  localparam int unsigned OW = $clog2(MaxOutst + 1);
  localparam int unsigned TW = (Timeout > 1) ? $clog2(Timeout) : 1;

  logic [OW-1:0] outst_q, outst_d;
  logic [TW-1:0] timer_q, timer_d;

  assign cap_o     = (outst_q == OW'(MaxOutst));
  assign empty_o   = (outst_q == '0);
  assign timeout_o = (timer_q == TW'(Timeout - 1));

  always_comb begin
    outst_d = outst_q;
    timer_d = timer_q;
    if (clear_i) begin
      outst_d = '0;
      timer_d = '0;
    end else begin
      // Simultaneous accept and response leaves the count unchanged; guards stop any wrap.
      if (accept_i && !resp_i && !cap_o) begin
        outst_d = outst_q + OW'(1);
      end else if (resp_i && !accept_i && !empty_o) begin
        outst_d = outst_q - OW'(1);
      end
      if (resp_i || empty_o) begin
        timer_d = '0;
      end else if (!timeout_o) begin
        timer_d = timer_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outst_q <= '0;
      timer_q <= '0;
    end else begin
      outst_q <= outst_d;
      timer_q <= timer_d;
    end
  end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Two-master round-robin arbiter for the shared pipelined Wishbone peripheral bus.
//   i_clk, i_resetn          : clock, asynchronous active-low reset
//   i_mN_* / o_mN_*          : master N (0 = core data port, 1 = loader/DMA) bus port
//   o_wb_* / i_wb_*          : single master-side port towards the decode/response fabric
//   o_grant                  : one-hot current owner
// One master owns the bus for as long as it holds cyc. Outstanding requests are capped at
// MAX_OUTST; a slave silent for TIMEOUT cycles aborts the cycle with a single err to the owner.
module wb_bus_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned AW        = DefAw,
  parameter int unsigned DW        = DefDw,
  parameter int unsigned MAX_OUTST = DefMaxOutst,
  parameter int unsigned TIMEOUT   = DefTimeout
) (
  input  logic            i_clk,
  input  logic            i_resetn,
  input  logic            i_m0_cyc,
  input  logic            i_m0_stb,
  input  logic            i_m0_we,
  input  logic [AW-1:0]   i_m0_addr,
  input  logic [DW-1:0]   i_m0_data,
  input  logic [DW/8-1:0] i_m0_sel,
  output logic            o_m0_stall,
  output logic            o_m0_ack,
  output logic            o_m0_err,
  output logic [DW-1:0]   o_m0_data,
  input  logic            i_m1_cyc,
  input  logic            i_m1_stb,
  input  logic            i_m1_we,
  input  logic [AW-1:0]   i_m1_addr,
  input  logic [DW-1:0]   i_m1_data,
  input  logic [DW/8-1:0] i_m1_sel,
  output logic            o_m1_stall,
  output logic            o_m1_ack,
  output logic            o_m1_err,
  output logic [DW-1:0]   o_m1_data,
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic            o_wb_we,
  output logic [AW-1:0]   o_wb_addr,
  output logic [DW-1:0]   o_wb_data,
  output logic [DW/8-1:0] o_wb_sel,
  input  logic            i_wb_stall,
  input  logic            i_wb_ack,
  input  logic            i_wb_err,
  input  logic [DW-1:0]   i_wb_data,
  output logic [1:0]      o_grant
);

  arb_state_t  state_q, state_d;
  master_idx_t owner_q, owner_d;
  master_idx_t rr_q, rr_d;  // master favoured when both request together
  logic        err_first_q, err_first_d;

  logic            own_cyc, own_stb, own_we;
  logic [AW-1:0]   own_addr;
  logic [DW-1:0]   own_data;
  logic [DW/8-1:0] own_sel;

  logic fwd_stb, own_stall, fwd_ack, fwd_err;
  logic accept, resp, clear, cap, empty, timeout;

  // Owner's request signals, muxed on the registered owner only.
  assign own_cyc  = owner_q[0] ? i_m1_cyc  : i_m0_cyc;
  assign own_stb  = owner_q[0] ? i_m1_stb  : i_m0_stb;
  assign own_we   = owner_q[0] ? i_m1_we   : i_m0_we;
  assign own_addr = owner_q[0] ? i_m1_addr : i_m0_addr;
  assign own_data = owner_q[0] ? i_m1_data : i_m0_data;
  assign own_sel  = owner_q[0] ? i_m1_sel  : i_m0_sel;

  // Tracking is dropped whenever the next cycle will not be an owned bus cycle.
  assign clear = (state_q != StOwn) || !own_cyc || timeout;

  wb_arb_tracker #(
    .MaxOutst (MAX_OUTST),
    .Timeout  (TIMEOUT)
  ) u_tracker (
    .clk_i     (i_clk),
    .rst_ni    (i_resetn),
    .accept_i  (accept),
    .resp_i    (resp),
    .clear_i   (clear),
    .cap_o     (cap),
    .empty_o   (empty),
    .timeout_o (timeout)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_d        = rr_q;
    err_first_d = 1'b0;

    o_wb_cyc   = 1'b0;
    o_wb_stb   = 1'b0;
    o_wb_we    = 1'b0;
    o_wb_addr  = '0;
    o_wb_data  = '0;
    o_wb_sel   = '0;
    o_m0_stall = 1'b1;
    o_m0_ack   = 1'b0;
    o_m0_err   = 1'b0;
    o_m0_data  = '0;
    o_m1_stall = 1'b1;
    o_m1_ack   = 1'b0;
    o_m1_err   = 1'b0;
    o_m1_data  = '0;
    o_grant    = 2'b00;
    fwd_stb    = 1'b0;
    own_stall  = 1'b1;
    fwd_ack    = 1'b0;
    fwd_err    = 1'b0;
    accept     = 1'b0;
    resp       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_m0_cyc || i_m1_cyc) begin
          state_d = StOwn;
          owner_d = (i_m0_cyc && i_m1_cyc) ? rr_q : i_m1_cyc;
        end
      end

      StOwn: begin
        fwd_stb   = own_cyc && own_stb && !cap;
        own_stall = i_wb_stall || cap;
        accept    = fwd_stb && !i_wb_stall;
        // Responses with nothing outstanding are stray and never reach a master.
        fwd_ack   = i_wb_ack && !empty;
        fwd_err   = i_wb_err && !empty;
        resp      = fwd_ack || fwd_err;

        o_wb_cyc  = own_cyc;
        o_wb_stb  = fwd_stb;
        o_wb_we   = own_we;
        o_wb_addr = own_addr;
        o_wb_data = own_data;
        o_wb_sel  = own_sel;
        o_grant   = onehot(owner_q);

        if (owner_q[0]) begin
          o_m1_stall = own_stall;
          o_m1_ack   = fwd_ack;
          o_m1_err   = fwd_err;
          o_m1_data  = i_wb_data;
        end else begin
          o_m0_stall = own_stall;
          o_m0_ack   = fwd_ack;
          o_m0_err   = fwd_err;
          o_m0_data  = i_wb_data;
        end

        // Owner releasing cyc takes priority over a coincident timeout.
        if (!own_cyc) begin
          state_d = StIdle;
          rr_d    = ~owner_q;
        end else if (timeout) begin
          state_d     = StAbort;
          err_first_d = 1'b1;
        end
      end

      StAbort: begin
        o_grant = onehot(owner_q);
        if (owner_q[0]) begin
          o_m1_err = err_first_q;
        end else begin
          o_m0_err = err_first_q;
        end
        if (!own_cyc) begin
          state_d = StIdle;
          rr_d    = ~owner_q;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q     <= StIdle;
      owner_q     <= '0;
      rr_q        <= '0;
      err_first_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_q        <= rr_d;
      err_first_q <= err_first_d;
    end
  end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Bench for wb_bus_arbiter: directed scenarios with literal expectations, then randomized
// master/slave traffic. A behavioural model (owner, outstanding count, silent-cycle count,
// favoured master) predicts every output on every cycle.
module tb_wb_bus_arbiter;

  localparam int unsigned AW   = 30;
  localparam int unsigned DW   = 32;
  localparam int unsigned SW   = DW / 8;
  localparam int unsigned MAXO = 4;
  localparam int unsigned TMO  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]    m_cyc, m_stb, m_we;
  logic [AW-1:0] m_addr  [2];
  logic [DW-1:0] m_wdata [2];
  logic [SW-1:0] m_sel   [2];

  logic          stall0, ack0, err0, stall1, ack1, err1;
  logic [DW-1:0] rd0, rd1;
  logic          wb_cyc, wb_stb, wb_we;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_wdata;
  logic [SW-1:0] wb_sel;
  logic [1:0]    grant;

  logic          s_stall, s_ack, s_err;
  logic [DW-1:0] s_rdata;

  wb_bus_arbiter #(
    .AW        (AW),
    .DW        (DW),
    .MAX_OUTST (MAXO),
    .TIMEOUT   (TMO)
  ) dut (
    .i_clk      (clk),
    .i_resetn   (rst_n),
    .i_m0_cyc   (m_cyc[0]),
    .i_m0_stb   (m_stb[0]),
    .i_m0_we    (m_we[0]),
    .i_m0_addr  (m_addr[0]),
    .i_m0_data  (m_wdata[0]),
    .i_m0_sel   (m_sel[0]),
    .o_m0_stall (stall0),
    .o_m0_ack   (ack0),
    .o_m0_err   (err0),
    .o_m0_data  (rd0),
    .i_m1_cyc   (m_cyc[1]),
    .i_m1_stb   (m_stb[1]),
    .i_m1_we    (m_we[1]),
    .i_m1_addr  (m_addr[1]),
    .i_m1_data  (m_wdata[1]),
    .i_m1_sel   (m_sel[1]),
    .o_m1_stall (stall1),
    .o_m1_ack   (ack1),
    .o_m1_err   (err1),
    .o_m1_data  (rd1),
    .o_wb_cyc   (wb_cyc),
    .o_wb_stb   (wb_stb),
    .o_wb_we    (wb_we),
    .o_wb_addr  (wb_addr),
    .o_wb_data  (wb_wdata),
    .o_wb_sel   (wb_sel),
    .i_wb_stall (s_stall),
    .i_wb_ack   (s_ack),
    .i_wb_err   (s_err),
    .i_wb_data  (s_rdata),
    .o_grant    (grant)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: owner (-1 = bus free), abort flag, one-shot err, outstanding requests,
  // consecutive cycles with requests outstanding and no response, favoured master.
  int md_owner, md_outst, md_silent, md_fav;
  bit md_abort, md_err_once;

  task automatic model_reset();
    md_owner = -1; md_outst = 0; md_silent = 0; md_fav = 0;
    md_abort = 1'b0; md_err_once = 1'b0;
  endtask

  task automatic check_and_step();
    logic [68:0] e_fab;
    logic [DW+2:0] e_m [2];
    logic [1:0] e_grant;
    bit capped, stbf, resp, acc;
    int o;
    e_fab   = '0;
    e_m[0]  = {1'b1, 2'b00, {DW{1'b0}}};
    e_m[1]  = {1'b1, 2'b00, {DW{1'b0}}};
    e_grant = 2'b00;
    capped  = (md_outst == MAXO);
    stbf    = 1'b0;
    resp    = 1'b0;
    o       = md_owner;
    if (o >= 0) begin
      e_grant = (o == 0) ? 2'b01 : 2'b10;
      if (!md_abort) begin
        stbf   = m_cyc[o] && m_stb[o] && !capped;
        e_fab  = {m_cyc[o], stbf, m_we[o], m_addr[o], m_wdata[o], m_sel[o]};
        resp   = (s_ack || s_err) && (md_outst > 0);
        e_m[o] = {s_stall || capped, s_ack && md_outst > 0, s_err && md_outst > 0, s_rdata};
      end else begin
        e_m[o] = {1'b1, 1'b0, md_err_once, {DW{1'b0}}};
      end
    end
    chk("fabric", 128'({wb_cyc, wb_stb, wb_we, wb_addr, wb_wdata, wb_sel}), 128'(e_fab));
    chk("m0", 128'({stall0, ack0, err0, rd0}), 128'(e_m[0]));
    chk("m1", 128'({stall1, ack1, err1, rd1}), 128'(e_m[1]));
    chk("grant", 128'(grant), 128'(e_grant));

    if (o < 0) begin
      if (m_cyc != 2'b00) begin
        md_owner  = (m_cyc == 2'b11) ? md_fav : (m_cyc[1] ? 1 : 0);
        md_outst  = 0;
        md_silent = 0;
      end
    end else if (!m_cyc[o]) begin
      md_fav = 1 - o; md_owner = -1; md_abort = 1'b0; md_err_once = 1'b0;
      md_outst = 0; md_silent = 0;
    end else if (md_abort) begin
      md_err_once = 1'b0;
    end else if (md_silent == TMO - 1) begin
      md_abort = 1'b1; md_err_once = 1'b1; md_outst = 0; md_silent = 0;
    end else begin
      acc       = stbf && !s_stall;
      md_silent = (md_outst > 0 && !resp) ? md_silent + 1 : 0;
      md_outst  = md_outst + int'(acc) - int'(resp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_and_step();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_inputs();
    m_cyc = '0; m_stb = '0; m_we = '0;
    for (int i = 0; i < 2; i++) begin
      m_addr[i] = '0; m_wdata[i] = '0; m_sel[i] = '0;
    end
    s_stall = 1'b0; s_ack = 1'b0; s_err = 1'b0; s_rdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    zero_inputs();
    model_reset();
    #1;
    chk("reset outputs", 128'({wb_cyc, wb_stb, stall0, stall1, ack0, err0, ack1, err1, grant}),
        128'(10'b0011000000));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  int n, issued, acks, ph;
  bit got;
  int due[$];

  initial begin
    zero_inputs();
    model_reset();
    #3;
    do_reset();

    // M0 single read, slave answers two cycles after accept.
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0; m_addr[0] = 30'h10; m_sel[0] = '1;
    #1;
    chk("t1 idle grant", 128'(grant), 128'(2'b00));
    tick();
    chk("t1 grant", 128'(grant), 128'(2'b01));
    chk("t1 fwd", 128'({wb_stb, wb_addr}), 128'({1'b1, 30'h10}));
    tick();
    m_stb[0] = 1'b0;
    tick();
    s_ack = 1'b1; s_rdata = 32'hDEADBEEF;
    #1;
    chk("t1 ack", 128'({ack0, rd0}), 128'({1'b1, 32'hDEADBEEF}));
    chk("t1 m1 stall", 128'(stall1), 128'(1'b1));
    tick();
    s_ack = 1'b0; m_cyc[0] = 1'b0;
    tick();
    tick();

    // Contention and alternation.
    do_reset();
    m_cyc = 2'b11;
    tick();
    chk("t2 first", 128'(grant), 128'(2'b01));
    m_cyc[0] = 1'b0;
    tick();
    chk("t2 gap", 128'(grant), 128'(2'b00));
    tick();
    chk("t2 second", 128'(grant), 128'(2'b10));
    m_cyc = 2'b00;
    tick();
    m_cyc = 2'b11;
    tick();
    chk("t2 alternate", 128'(grant), 128'(2'b01));
    m_cyc = 2'b00;
    tick();
    tick();

    // Six back-to-back requests against a slave answering 8 cycles after each accept.
    do_reset();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    tick();
    issued = 0; acks = 0; due.delete();
    for (int t = 0; t < 40; t++) begin
      s_ack = (due.size() > 0 && due[0] == t);
      if (s_ack) void'(due.pop_front());
      m_stb[0] = (issued < 6);
      #1;
      if (t == 4) chk("t3 cap stall", 128'({stall0, wb_stb}), 128'(2'b10));
      if (wb_stb && !stall0) begin
        issued++;
        due.push_back(t + 8);
      end
      if (ack0) acks++;
      tick();
    end
    s_ack = 1'b0;
    chk("t3 acks", 128'(acks), 128'(6));
    chk("t3 issued", 128'(issued), 128'(6));
    m_cyc[0] = 1'b0;
    tick();

    // Timeout: one read from M1 that is never answered.
    do_reset();
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    tick();
    tick();
    m_stb[1] = 1'b0;
    n = 0; got = 1'b0;
    for (int i = 1; i <= 40 && !got; i++) begin
      tick();
      n = i;
      got = err1;
    end
    chk("t4 err delay", 128'(n), 128'(16));
    chk("t4 abort cyc", 128'(wb_cyc), 128'(1'b0));
    tick();
    chk("t4 err once", 128'({err1, stall1}), 128'(2'b01));
    m_cyc[1] = 1'b0;
    tick();
    chk("t4 idle", 128'(grant), 128'(2'b00));

    // Stray response while idle.
    s_ack = 1'b1; s_err = 1'b1;
    #1;
    chk("t5 stray", 128'({ack0, ack1, err0, err1}), 128'(4'b0000));
    tick();
    s_ack = 1'b0; s_err = 1'b0;

    // Reset with three requests outstanding.
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    tick(); tick(); tick(); tick();
    m_stb[0] = 1'b0;
    #2;
    rst_n = 1'b0;
    s_ack = 1'b1;
    #1;
    chk("t6 async reset", 128'({wb_cyc, wb_stb, stall0, stall1, ack0, err0, grant}),
        128'(8'b00110000));
    do_reset();
    s_ack = 1'b1;
    tick(); tick(); tick();
    s_ack = 1'b0;

    // Randomized traffic; phases vary slave responsiveness so timeouts also occur.
    for (int t = 0; t < 3000; t++) begin
      for (int m = 0; m < 2; m++) begin
        if (m_cyc[m]) begin
          if ($urandom_range(15) == 0) m_cyc[m] = 1'b0;
        end else if ($urandom_range(5) == 0) begin
          m_cyc[m] = 1'b1;
        end
        m_stb[m]   = m_cyc[m] && ($urandom_range(1) == 1);
        m_we[m]    = ($urandom_range(1) == 1);
        m_addr[m]  = AW'($urandom);
        m_wdata[m] = $urandom;
        m_sel[m]   = SW'($urandom);
      end
      ph      = (t / 250) % 3;
      s_stall = ($urandom_range(3) == 0);
      s_ack   = (ph == 0) ? ($urandom_range(2) == 0) :
                (ph == 1) ? ($urandom_range(30) == 0) : 1'b0;
      s_err   = ($urandom_range(60) == 0);
      s_rdata = $urandom;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
